dram_pingpong_shifter: RTL and testbench

DRAM_PINGPONG_SHIFTER -- requirements
Module: dram_pingpong_shifter

---
 rtl/dram_shifter_pkg.sv | 18 +
 rtl/dram_shifter_dpram.sv | 40 ++++
 rtl/dram_pingpong_shifter.sv | 124 ++++++++++++
 tb/tb_dram_pingpong_shifter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_shifter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_shifter_pkg                                                           |
// | Default geometry and RAM depth helper for dram_pingpong_shifter.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dram_shifter_pkg;

    localparam int c_DEF_IO_WIDTH   = 16;
    localparam int c_DEF_ADDR_WIDTH = 6;

    // Two banks of 2**ADDR_WIDTH bits each.
    function automatic int depth(input int addr_width);
        return 2 ** (addr_width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_shifter_dpram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_shifter_dpram                                                         |
// | 1-bit wide RAM: synchronous write port, asynchronous read port, no reset.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dram_shifter_dpram
    import dram_shifter_pkg::*;
#(
    parameter int                         ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter logic [depth(ADDR_WIDTH)-1:0] INIT     = '0
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH:0]   waddr,
    input  logic                  wdata,
    input  logic [ADDR_WIDTH:0]   raddr,
    output logic                  rdata
);

    localparam int c_DEPTH = depth(ADDR_WIDTH);

    logic r_mem_q [c_DEPTH];
    logic w_wbit_d;

    // Cells hold data XOR INIT, so power-up-zero storage reads back as INIT.
    always_comb begin
        w_wbit_d = wdata ^ INIT[waddr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem_q[waddr] <= w_wbit_d;
        end
    end

    assign rdata = r_mem_q[raddr] ^ INIT[raddr];

endmodule
`default_nettype wire

// File: rtl/dram_pingpong_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_pingpong_shifter                                                      |
// | Ping-pong bit-serial frame buffer; DRAM_SHIFTER_HOLD_EN adds a hold input. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dram_pingpong_shifter
    import dram_shifter_pkg::*;
#(
    parameter int                           IO_WIDTH   = c_DEF_IO_WIDTH,
    parameter int                           ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter logic [depth(ADDR_WIDTH)-1:0] INIT       = '0
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef DRAM_SHIFTER_HOLD_EN
    input  logic                hold,
`endif
    input  logic [IO_WIDTH-1:0] in,
    input  logic                swap_req,
    output logic [IO_WIDTH-1:0] out,
    output logic                frame_done,
    output logic                swap_ack,
    output logic                bank
);

    localparam int              c_CW   = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(IO_WIDTH - 1);

    generate
        if ((IO_WIDTH < 1) || (IO_WIDTH > 2 ** ADDR_WIDTH)) begin : g_bad_cfg
            $error("dram_pingpong_shifter: IO_WIDTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    logic [c_CW-1:0]     r_cnt_q,    w_cnt_d;
    logic                r_bank_q,   w_bank_d;
    logic                r_pend_q,   w_pend_d;
    logic [IO_WIDTH-1:0] r_shadow_q, w_shadow_d;
    logic [IO_WIDTH-1:0] r_out_q,    w_out_d;
    logic                r_fd_q,     w_fd_d;
    logic                r_ack_q,    w_ack_d;

    logic                w_run;
    logic                w_boundary;
    logic                w_swap;
    logic                w_rd_bit;
    logic [ADDR_WIDTH:0] w_waddr;
    logic [ADDR_WIDTH:0] w_raddr;

`ifdef DRAM_SHIFTER_HOLD_EN
    assign w_run = ~hold;
`else
    assign w_run = 1'b1;
`endif

    assign w_boundary = w_run && (r_cnt_q == c_LAST);
    assign w_swap     = r_pend_q || swap_req;
    assign w_waddr    = {r_bank_q,  ADDR_WIDTH'(r_cnt_q)};
    assign w_raddr    = {~r_bank_q, ADDR_WIDTH'(r_cnt_q)};

    dram_shifter_dpram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT       (INIT)
    ) u_ram (
        .clk   (clk),
        .we    (w_run),
        .waddr (w_waddr),
        .wdata (in[r_cnt_q]),
        .raddr (w_raddr),
        .rdata (w_rd_bit)
    );

    always_comb begin
        w_cnt_d    = r_cnt_q;
        w_bank_d   = r_bank_q;
        w_pend_d   = r_pend_q | swap_req;
        w_shadow_d = r_shadow_q;
        w_out_d    = r_out_q;
        w_fd_d     = w_boundary;
        w_ack_d    = w_boundary && w_swap;

        if (w_run) begin
            w_shadow_d[r_cnt_q] = w_rd_bit;
            w_cnt_d             = (r_cnt_q == c_LAST) ? '0 : r_cnt_q + 1'b1;
        end

        // out takes the whole frame at once, including the bit read this cycle.
        if (w_boundary) begin
            w_out_d  = w_shadow_d;
            w_pend_d = 1'b0;
            if (w_swap) begin
                w_bank_d = ~r_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q    <= '0;
            r_bank_q   <= 1'b0;
            r_pend_q   <= 1'b0;
            r_shadow_q <= '0;
            r_out_q    <= '0;
            r_fd_q     <= 1'b0;
            r_ack_q    <= 1'b0;
        end else begin
            r_cnt_q    <= w_cnt_d;
            r_bank_q   <= w_bank_d;
            r_pend_q   <= w_pend_d;
            r_shadow_q <= w_shadow_d;
            r_out_q    <= w_out_d;
            r_fd_q     <= w_fd_d;
            r_ack_q    <= w_ack_d;
        end
    end

    assign out        = r_out_q;
    assign frame_done = r_fd_q;
    assign swap_ack   = r_ack_q;
    assign bank       = r_bank_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_pingpong_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dram_pingpong_shifter                                                   |
// | Scoreboard plus scenario table for dram_pingpong_shifter (16/6/INIT=0).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dram_pingpong_shifter;

    localparam int W = 16;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         swap_req = 1'b0;
    logic [W-1:0] in_d     = '0;
    logic [W-1:0] out;
    logic         frame_done;
    logic         swap_ack;
    logic         bank;
`ifdef DRAM_SHIFTER_HOLD_EN
    logic         hold     = 1'b0;
`endif

    always #5 clk = ~clk;

    dram_pingpong_shifter #(
        .IO_WIDTH   (16),
        .ADDR_WIDTH (6),
        .INIT       ('0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DRAM_SHIFTER_HOLD_EN
        .hold       (hold),
`endif
        .in         (in_d),
        .swap_req   (swap_req),
        .out        (out),
        .frame_done (frame_done),
        .swap_ack   (swap_ack),
        .bank       (bank)
    );

    typedef struct packed {
        logic [W-1:0] out;
        logic         fd;
        logic         ack;
        logic         bank;
    } exp_t;

    typedef struct {
        logic [W-1:0] in;
        int           swap_a;
        int           swap_b;
        logic [W-1:0] out16;
        logic         bank16;
        logic         ack16;
        logic [W-1:0] out32;
        logic         bank32;
        logic         ack32;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: two bank words, frame-level read at each boundary.
    logic [W-1:0] m_ram [2];
    int           m_cnt;
    logic         m_bank, m_pend, m_fd, m_ack;
    logic [W-1:0] m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_bank = 1'b0;
        m_pend = 1'b0;
        m_fd   = 1'b0;
        m_ack  = 1'b0;
        m_out  = '0;
    endtask

    task automatic model_step(input logic [W-1:0] din, input logic sr, input logic h);
        if (h) begin
            m_pend = m_pend | sr;
            m_fd   = 1'b0;
            m_ack  = 1'b0;
        end else begin
            m_ram[m_bank][m_cnt] = din[m_cnt];
            if (m_cnt == W - 1) begin
                m_out = m_ram[!m_bank];
                m_fd  = 1'b1;
                m_ack = m_pend | sr;
                if (m_ack) m_bank = !m_bank;
                m_pend = 1'b0;
                m_cnt  = 0;
            end else begin
                m_fd   = 1'b0;
                m_ack  = 1'b0;
                m_pend = m_pend | sr;
                m_cnt++;
            end
        end
    endtask

    // Entered at a falling edge: compare this cycle, drive it, predict the next.
    task automatic cycle(input logic sr, input logic h);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            chk("sb_out",  32'(out),        32'(e.out));
            chk("sb_fd",   32'(frame_done), 32'(e.fd));
            chk("sb_ack",  32'(swap_ack),   32'(e.ack));
            chk("sb_bank", 32'(bank),       32'(e.bank));
        end
        swap_req = sr;
`ifdef DRAM_SHIFTER_HOLD_EN
        hold = h;
`endif
        model_step(in_d, sr, h);
        sb_q.push_back('{out: m_out, fd: m_fd, ack: m_ack, bank: m_bank});
        @(negedge clk);
    endtask

    // Entered and left at a falling edge; on exit the cycle-0 state is queued.
    task automatic do_reset();
        rst_n    = 1'b0;
        swap_req = 1'b0;
`ifdef DRAM_SHIFTER_HOLD_EN
        hold = 1'b0;
`endif
        #1;
        chk("rst_out",  32'(out),        32'h0);
        chk("rst_fd",   32'(frame_done), 32'h0);
        chk("rst_ack",  32'(swap_ack),   32'h0);
        chk("rst_bank", 32'(bank),       32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sb_q.delete();
        sb_q.push_back('{out: '0, fd: 1'b0, ack: 1'b0, bank: 1'b0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tab [6];
        int   seen;

        // RAM persists across resets, so each row depends on the rows before it.
        tab[0] = '{16'h0000, -1, -1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab[1] = '{16'hA5C3,  3, -1, 16'h0000, 1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0};
        tab[2] = '{16'h1234,  2,  9, 16'hA5C3, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0};
        tab[3] = '{16'hFFFF, 15, -1, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tab[4] = '{16'h0F0F, 16, -1, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1};
        tab[5] = '{16'h3C3C, 15, 16, 16'hFFFF, 1'b1, 1'b1, 16'h3C3C, 1'b0, 1'b1};

        m_ram[0] = '0;
        m_ram[1] = '0;
        model_reset();
        @(negedge clk);

        for (int s = 0; s < 6; s++) begin
            in_d = tab[s].in;
            do_reset();
            for (int k = 0; k <= 32; k++) begin
                if (k == 15) chk("t_fd15", 32'(frame_done), 32'h0);
                if (k == 16) begin
                    chk("t_fd16",   32'(frame_done), 32'h1);
                    chk("t_out16",  32'(out),        32'(tab[s].out16));
                    chk("t_bank16", 32'(bank),       32'(tab[s].bank16));
                    chk("t_ack16",  32'(swap_ack),   32'(tab[s].ack16));
                end
                if (k == 32) begin
                    chk("t_fd32",   32'(frame_done), 32'h1);
                    chk("t_out32",  32'(out),        32'(tab[s].out32));
                    chk("t_bank32", 32'(bank),       32'(tab[s].bank32));
                    chk("t_ack32",  32'(swap_ack),   32'(tab[s].ack32));
                end
                cycle((k == tab[s].swap_a) || (k == tab[s].swap_b), 1'b0);
            end
        end

        // Reset in the middle of the frame following a swap.
        in_d = 16'h5A5A;
        do_reset();
        for (int k = 0; k < 23; k++) cycle(k == 3, 1'b0);
        chk("pre_rst_bank", 32'(bank), 32'h1);
        do_reset();
        seen = -1;
        for (int k = 0; k < 40; k++) begin
            if (frame_done && seen < 0) seen = k;
            cycle(1'b0, 1'b0);
        end
        chk("rst_fd_latency", 32'(seen), 32'd16);

`ifdef DRAM_SHIFTER_HOLD_EN
        // Five-cycle pause mid-frame shifts every boundary by five cycles.
        in_d = 16'hC33C;
        do_reset();
        seen = -1;
        for (int k = 0; k <= 40; k++) begin
            if (frame_done && seen < 0) seen = k;
            if (k == 21) chk("hold_bank21", 32'(bank), 32'h1);
            if (k == 37) begin
                chk("hold_fd37",  32'(frame_done), 32'h1);
                chk("hold_out37", 32'(out),        32'hC33C);
            end
            cycle(k == 2, (k >= 5) && (k <= 9));
        end
        chk("hold_fd_latency", 32'(seen), 32'd21);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
